// File: rtl/bp_read_sched.sv
// Branch-predictor read scheduler: a small FIFO of committed direction updates
// shares one BP/PC-file read slot with mispredict recovery (recovery wins).
module bp_read_sched #(
  parameter int DEPTH       = 4,
  parameter int FETCH_ID_W  = 5,
  parameter int FETCH_OFF_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,

  input  logic                   IN_mispr_valid,
  input  logic [FETCH_ID_W-1:0]  IN_mispr_fetchID,
  input  logic                   IN_mispr_manual,

  input  logic                   IN_upd_valid,
  input  logic [FETCH_ID_W-1:0]  IN_upd_fetchID,
  input  logic [FETCH_OFF_W-1:0] IN_upd_offs,
  input  logic                   IN_upd_taken,
  output logic                   OUT_upd_ready,

  output logic                   OUT_bpRead_valid,
  output logic [FETCH_ID_W-1:0]  OUT_bpRead_addr,
  output logic                   OUT_pcRead_valid,
  output logic [FETCH_ID_W-1:0]  OUT_pcRead_addr,

  output logic                   OUT_act_valid,
  output logic                   OUT_act_isRec,
  output logic [FETCH_ID_W-1:0]  OUT_act_fetchID,
  output logic [FETCH_OFF_W-1:0] OUT_act_offs,
  output logic                   OUT_act_taken,

  output logic                   OUT_fetchLimit_valid,
  output logic [FETCH_ID_W-1:0]  OUT_fetchLimit_fetchID,
  output logic [$clog2(DEPTH+1)-1:0] OUT_pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [FETCH_ID_W-1:0]  idMem  [DEPTH];
  logic [FETCH_OFF_W-1:0] offMem [DEPTH];
  logic [DEPTH-1:0]       takenMem;

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;

  logic grantRec;
  logic grantUpd;
  logic doPush;
  logic doPop;

  logic                   actValid;
  logic                   actIsRec;
  logic [FETCH_ID_W-1:0]  actFetchID;
  logic [FETCH_OFF_W-1:0] actOffs;
  logic                   actTaken;

  // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
  assign OUT_upd_ready = (count < CNT_W'(DEPTH));
  assign OUT_pending   = count;

  assign grantRec = IN_mispr_valid;
  assign grantUpd = !IN_mispr_valid && (count != '0);
  assign doPush   = IN_upd_valid && OUT_upd_ready;
  assign doPop    = grantUpd;

  always_comb begin
    OUT_bpRead_valid = 1'b0;
    OUT_bpRead_addr  = '0;
    OUT_pcRead_valid = 1'b0;
    OUT_pcRead_addr  = '0;
    if (grantRec) begin
      OUT_bpRead_valid = 1'b1;
      OUT_bpRead_addr  = IN_mispr_fetchID;
      OUT_pcRead_valid = !IN_mispr_manual;
      OUT_pcRead_addr  = IN_mispr_fetchID;
    end else if (grantUpd) begin
      OUT_bpRead_valid = 1'b1;
      OUT_bpRead_addr  = idMem[rdPtr];
      OUT_pcRead_valid = 1'b1;
      OUT_pcRead_addr  = idMem[rdPtr];
    end
  end

  // Fetch must not run past the oldest update that has not yet read its BP entry.
  always_comb begin
    OUT_fetchLimit_valid  = 1'b0;
    OUT_fetchLimit_fetchID = '0;
    if (count != '0) begin
      OUT_fetchLimit_valid   = 1'b1;
      OUT_fetchLimit_fetchID = idMem[rdPtr];
    end else if (IN_upd_valid) begin
      OUT_fetchLimit_valid   = 1'b1;
      OUT_fetchLimit_fetchID = IN_upd_fetchID;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) begin
      idMem[wrPtr]    <= IN_upd_fetchID;
      offMem[wrPtr]   <= IN_upd_offs;
      takenMem[wrPtr] <= IN_upd_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Descriptor lines up with the one-cycle read latency of the BP and PC files.
  always_ff @(posedge clk) begin
    if (!rst) actValid <= 1'b0;
    else      actValid <= grantRec || grantUpd;
    actIsRec   <= grantRec;
    actFetchID <= OUT_bpRead_addr;
    actOffs    <= offMem[rdPtr];
    actTaken   <= takenMem[rdPtr];
  end

  assign OUT_act_valid   = actValid;
  assign OUT_act_isRec   = actIsRec;
  assign OUT_act_fetchID = actFetchID;
  assign OUT_act_offs    = actOffs;
  assign OUT_act_taken   = actTaken;

endmodule

// File: tb/tb_bp_read_sched.sv
// Scoreboard bench for bp_read_sched: stimulus queues expected grants, a
// negedge monitor checks each read and the descriptor that follows it.
module tb_bp_read_sched;

  localparam int DEPTH = 4;
  localparam int IDW   = 5;
  localparam int OFFW  = 3;

  logic clk = 1'b0;
  logic rst;
  logic            IN_mispr_valid;
  logic [IDW-1:0]  IN_mispr_fetchID;
  logic            IN_mispr_manual;
  logic            IN_upd_valid;
  logic [IDW-1:0]  IN_upd_fetchID;
  logic [OFFW-1:0] IN_upd_offs;
  logic            IN_upd_taken;
  logic            OUT_upd_ready;
  logic            OUT_bpRead_valid;
  logic [IDW-1:0]  OUT_bpRead_addr;
  logic            OUT_pcRead_valid;
  logic [IDW-1:0]  OUT_pcRead_addr;
  logic            OUT_act_valid;
  logic            OUT_act_isRec;
  logic [IDW-1:0]  OUT_act_fetchID;
  logic [OFFW-1:0] OUT_act_offs;
  logic            OUT_act_taken;
  logic            OUT_fetchLimit_valid;
  logic [IDW-1:0]  OUT_fetchLimit_fetchID;
  logic [$clog2(DEPTH+1)-1:0] OUT_pending;

  bp_read_sched #(.DEPTH(DEPTH), .FETCH_ID_W(IDW), .FETCH_OFF_W(OFFW)) dut (
    .clk(clk), .rst(rst),
    .IN_mispr_valid(IN_mispr_valid), .IN_mispr_fetchID(IN_mispr_fetchID),
    .IN_mispr_manual(IN_mispr_manual),
    .IN_upd_valid(IN_upd_valid), .IN_upd_fetchID(IN_upd_fetchID),
    .IN_upd_offs(IN_upd_offs), .IN_upd_taken(IN_upd_taken),
    .OUT_upd_ready(OUT_upd_ready),
    .OUT_bpRead_valid(OUT_bpRead_valid), .OUT_bpRead_addr(OUT_bpRead_addr),
    .OUT_pcRead_valid(OUT_pcRead_valid), .OUT_pcRead_addr(OUT_pcRead_addr),
    .OUT_act_valid(OUT_act_valid), .OUT_act_isRec(OUT_act_isRec),
    .OUT_act_fetchID(OUT_act_fetchID), .OUT_act_offs(OUT_act_offs),
    .OUT_act_taken(OUT_act_taken),
    .OUT_fetchLimit_valid(OUT_fetchLimit_valid),
    .OUT_fetchLimit_fetchID(OUT_fetchLimit_fetchID),
    .OUT_pending(OUT_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             isRec;
    logic [IDW-1:0] id;
    bit             pcV;
    logic [OFFW-1:0] offs;
    bit             taken;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  bit   actPend = 1'b0;
  bit   monEn = 1'b0;
  int   checkCount = 0;
  int   passCount = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checkCount++;
    if (act === req) passCount++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic expRec(input int id, input bit manual);
    exp_t e;
    e.isRec = 1'b1; e.id = IDW'(id); e.pcV = !manual; e.offs = '0; e.taken = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic expUpd(input int id);
    exp_t e;
    logic [31:0] v;
    v = id;
    e.isRec = 1'b0; e.id = IDW'(id); e.pcV = 1'b1; e.offs = v[OFFW-1:0]; e.taken = v[0];
    expQ.push_back(e);
  endtask

  task automatic offer(input int id);
    logic [31:0] v;
    v = id;
    IN_upd_valid   = 1'b1;
    IN_upd_fetchID = v[IDW-1:0];
    IN_upd_offs    = v[OFFW-1:0];
    IN_upd_taken   = v[0];
  endtask

  task automatic mispr(input bit valid, input int id, input bit manual);
    IN_mispr_valid   = valid;
    IN_mispr_fetchID = IDW'(id);
    IN_mispr_manual  = manual;
  endtask

  task automatic toNeg();
    @(negedge clk);
  endtask

  task automatic toNext();
    @(posedge clk);
    #1;
  endtask

  // Monitor: each read is matched against the next expected grant, and the
  // descriptor must follow one cycle later unless the grant happened in reset.
  always @(negedge clk) begin
    if (monEn) begin
      if (actPend) begin
        chk("act_valid", 32'(OUT_act_valid), 32'd1);
        chk("act_isRec", 32'(OUT_act_isRec), 32'(lastExp.isRec));
        chk("act_fetchID", 32'(OUT_act_fetchID), 32'(lastExp.id));
        if (!lastExp.isRec) begin
          chk("act_offs", 32'(OUT_act_offs), 32'(lastExp.offs));
          chk("act_taken", 32'(OUT_act_taken), 32'(lastExp.taken));
        end
      end else begin
        chk("act_idle", 32'(OUT_act_valid), 32'd0);
      end
      actPend = 1'b0;
      if (OUT_bpRead_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          chk("read_unexpected", 32'(OUT_bpRead_valid), 32'd0);
        end else begin
          lastExp = expQ.pop_front();
          chk("bpRead_addr", 32'(OUT_bpRead_addr), 32'(lastExp.id));
          chk("pcRead_valid", 32'(OUT_pcRead_valid), 32'(lastExp.pcV));
          if (lastExp.pcV) chk("pcRead_addr", 32'(OUT_pcRead_addr), 32'(lastExp.id));
          actPend = (rst === 1'b1);
        end
      end else begin
        chk("pcRead_idle", 32'(OUT_pcRead_valid), 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b0;
    IN_mispr_valid = 1'b0; IN_mispr_fetchID = '0; IN_mispr_manual = 1'b0;
    IN_upd_valid = 1'b0; IN_upd_fetchID = '0; IN_upd_offs = '0; IN_upd_taken = 1'b0;

    // reset state
    toNext();
    monEn = 1'b1;
    toNeg();
    chk("rst_ready", 32'(OUT_upd_ready), 32'd1);
    chk("rst_pending", 32'(OUT_pending), 32'd0);
    chk("rst_fl_valid", 32'(OUT_fetchLimit_valid), 32'd0);
    toNext();
    rst = 1'b1;
    toNext();

    // three updates in order, no bypass on the empty queue
    offer(5); expUpd(5);
    toNeg();
    chk("t1_fl_valid", 32'(OUT_fetchLimit_valid), 32'd1);
    chk("t1_fl_id", 32'(OUT_fetchLimit_fetchID), 32'd5);
    chk("t1_nobypass", 32'(OUT_bpRead_valid), 32'd0);
    toNext();
    offer(6); expUpd(6);
    toNext();
    offer(7); expUpd(7);
    toNext();
    IN_upd_valid = 1'b0;
    repeat (3) toNext();

    // manual mispredict preempts a queued update
    offer(2);
    toNext();
    IN_upd_valid = 1'b0;
    mispr(1'b1, 9, 1'b1); expRec(9, 1'b1); expUpd(2);
    toNeg();
    chk("t2_pending", 32'(OUT_pending), 32'd1);
    chk("t2_fl_id", 32'(OUT_fetchLimit_fetchID), 32'd2);
    toNext();
    mispr(1'b0, 0, 1'b0);
    repeat (2) toNext();

    // fill under continuous mispredicts, then push/pop while full
    mispr(1'b1, 20, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      offer(i); expRec(20, 1'b0);
      toNext();
    end
    offer(5);
    for (int i = 0; i < 2; i++) begin
      expRec(20, 1'b0);
      toNeg();
      chk("t3_full_ready", 32'(OUT_upd_ready), 32'd0);
      chk("t3_full_pending", 32'(OUT_pending), 32'd4);
      chk("t3_fl_id", 32'(OUT_fetchLimit_fetchID), 32'd1);
      toNext();
    end
    mispr(1'b0, 0, 1'b0);
    expUpd(1);
    toNeg();
    chk("t3_pushpop_ready", 32'(OUT_upd_ready), 32'd0);
    chk("t3_pushpop_pending", 32'(OUT_pending), 32'd4);
    toNext();
    expUpd(2);
    toNeg();
    chk("t3_after_ready", 32'(OUT_upd_ready), 32'd1);
    chk("t3_after_pending", 32'(OUT_pending), 32'd3);
    toNext();
    IN_upd_valid = 1'b0;
    expUpd(3); expUpd(4); expUpd(5);
    toNeg();
    chk("t3_steady_pending", 32'(OUT_pending), 32'd3);
    begin
      int budget;
      budget = 0;
      while (OUT_pending != 0 && budget < 20) begin
        toNext();
        budget++;
      end
      chk("t3_drain_in_budget", 32'(OUT_pending), 32'd0);
    end
    repeat (2) toNext();

    // empty queue: fetch limit passes through the incoming update
    offer(12); expUpd(12);
    toNeg();
    chk("t4_fl_valid", 32'(OUT_fetchLimit_valid), 32'd1);
    chk("t4_fl_id", 32'(OUT_fetchLimit_fetchID), 32'd12);
    chk("t4_nobypass", 32'(OUT_bpRead_valid), 32'd0);
    toNext();
    IN_upd_valid = 1'b0;
    repeat (2) toNext();

    // reset discards queued updates; mispredict during reset gives no descriptor
    mispr(1'b1, 21, 1'b0);
    for (int i = 13; i <= 15; i++) begin
      offer(i); expRec(21, 1'b0);
      toNext();
    end
    IN_upd_valid = 1'b0;
    rst = 1'b0; expRec(21, 1'b0);
    toNext();
    rst = 1'b1;
    mispr(1'b0, 0, 1'b0);
    toNeg();
    chk("t5_pending", 32'(OUT_pending), 32'd0);
    chk("t5_act_valid", 32'(OUT_act_valid), 32'd0);
    chk("t5_ready", 32'(OUT_upd_ready), 32'd1);
    chk("t5_fl_valid", 32'(OUT_fetchLimit_valid), 32'd0);
    repeat (4) toNext();

    chk("expected_reads_left", 32'(expQ.size()), 32'd0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bp_read_sched.md
BP_READ_SCHED -- requirements
Module: bp_read_sched

Interface
REQ-001 SHALL have parameter: DEPTH, 4, update queue entries (power of two, >=2).
REQ-002 SHALL have port: clk  in  1  clock; all state changes on posedge.
REQ-003 SHALL have port: rst  in  1  reset; one clock, synchronous, active-low (rst=0 resets).
REQ-004 SHALL have port: IN_mispr_valid  in  1  mispredict recovery request this cycle.
REQ-005 SHALL have port: IN_mispr_fetchID  in  FetchID_t  fetch ID to revert to.
REQ-006 SHALL have port: IN_mispr_manual  in  1  target is BR_TGT_MANUAL, so no PC read.
REQ-007 SHALL have port: IN_upd_valid  in  1  committed branch direction update offered.
REQ-008 SHALL have port: IN_upd_fetchID  in  FetchID_t  fetch ID of the update.
REQ-009 SHALL have port: IN_upd_offs  in  FetchOff_t  branch offset within the fetch packet.
REQ-010 SHALL have port: IN_upd_taken  in  1  resolved direction.
REQ-011 SHALL have port: OUT_upd_ready  out  1  queue accepts an update this cycle.
REQ-012 SHALL have port: OUT_bpRead_valid, OUT_bpRead_addr  out  1, FetchID_t  BP-file read port.
REQ-013 SHALL have port: OUT_pcRead_valid, OUT_pcRead_addr  out  1, FetchID_t  PC-file read port.
REQ-014 SHALL have port: OUT_act_valid, OUT_act_isRec  out  1, 1  descriptor of last cycle's grant.
REQ-015 SHALL have port: OUT_act_fetchID, OUT_act_offs, OUT_act_taken  out  FetchID_t, FetchOff_t, 1  granted request fields.
REQ-016 SHALL have port: OUT_fetchLimit_valid, OUT_fetchLimit_fetchID  out  1, FetchID_t  oldest unserviced update.
REQ-017 SHALL have port: OUT_pending  out  $clog2(DEPTH+1)  queued update count.

Function
REQ-018 SHALL hold updates in a FIFO of DEPTH entries; push when IN_upd_valid && OUT_upd_ready.
REQ-019 SHALL drive OUT_upd_ready = (count < DEPTH), combinationally from registered state only; a pop in the same cycle does not raise ready.
REQ-020 SHALL arbitrate the single read slot each cycle with fixed priority: mispredict, then FIFO head.
REQ-021 On a mispredict grant, SHALL assert OUT_bpRead_valid with addr=IN_mispr_fetchID, and assert OUT_pcRead_valid with the same addr only if !IN_mispr_manual.
REQ-022 On an update grant, SHALL pop the head and assert both read valids with addr=head fetchID.
REQ-023 SHALL drive addresses to don't-care and valids to 0 on cycles with no grant.
REQ-024 SHALL register the grant descriptor so OUT_act_* reflect the cycle-N grant during cycle N+1, aligned with the files' one-cycle read latency; OUT_act_offs/taken are don't-care when isRec=1.
REQ-025 SHALL NOT bypass: an update arriving on an empty queue is granted no earlier than the next cycle.
REQ-026 SHALL drive OUT_fetchLimit from the head if count>0, else from IN_upd_* if IN_upd_valid, else valid=0.
REQ-027 SHALL support simultaneous push and pop with count unchanged; pointers wrap modulo DEPTH.
REQ-028 SHALL drop an IN_upd_valid offered while full; the producer holds it until ready.
REQ-029 SHALL leave updates starved indefinitely under back-to-back mispredicts; FIFO order is preserved.

Reset
REQ-030 When rst=0 at a posedge, SHALL empty the FIFO (count 0, pointers 0) and clear OUT_act_valid.
REQ-031 During and after reset, SHALL drive OUT_upd_ready=1, OUT_pending=0 and OUT_fetchLimit_valid=0 if IN_upd_valid=0.
REQ-032 SHALL have read valids follow REQ-020 combinationally during reset; a mispredict in a reset cycle yields no OUT_act.
REQ-033 SHALL discard queued updates when reset is asserted mid-operation.

Verification
REQ-034 Push 3 updates (IDs 5,6,7), no mispredicts -> reads at IDs 5,6,7 in cycles 1,2,3 after the first push; OUT_act_isRec=0 one cycle later each.
REQ-035 Queue holds ID 2; mispredict ID 9 manual=1 -> bpRead ID 9, pcRead_valid=0, head stays 2; next cycle OUT_act_isRec=1, ID 9, and ID 2 is granted.
REQ-036 Fill 4 updates with mispredicts asserted -> OUT_upd_ready=0, OUT_pending=4, fetchLimit ID = first pushed; 5th offer not accepted.
REQ-037 Full queue, push and pop in the same cycle -> ready stays 0 that cycle, pending stays 4.
REQ-038 Empty queue, IN_upd_valid ID 12 -> fetchLimit valid with ID 12 in the same cycle; read of ID 12 next cycle.
REQ-039 3 queued, rst=0 for one cycle -> pending=0, OUT_act_valid=0, no update reads afterwards.
